// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encoding, grant encodings and the zero data word.
package wb_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_M0 = 2'b01,
    GNT_M1 = 2'b10
  } arb_state_e;

  localparam logic [1:0]  GRANT_NONE = 2'b00;
  localparam logic [1:0]  GRANT_M0   = 2'b01;
  localparam logic [1:0]  GRANT_M1   = 2'b10;

  localparam logic [31:0] ZeroWord   = 32'h0;

  localparam int unsigned WD_CNT_W   = 16;

  function automatic logic [1:0] grant_of(input arb_state_e s);
    logic [1:0] g;
    g = GRANT_NONE;
    case (s)
      GNT_M0:  g = GRANT_M0;
      GNT_M1:  g = GRANT_M1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_master_arbiter_if.sv
// Bus bundle for wb_master_arbiter: both master ports plus the shared slave side.
interface wb_master_arbiter_if;

  logic [31:0] m0_addr_i;
  logic [31:0] m0_data_i;
  logic        m0_we_i;
  logic        m0_stb_i;
  logic        m0_cyc_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_data_o;
  logic        m0_ack_o;

  logic [31:0] m1_addr_i;
  logic [31:0] m1_data_i;
  logic        m1_we_i;
  logic        m1_stb_i;
  logic        m1_cyc_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_data_o;
  logic        m1_ack_o;

  logic [31:0] s_addr_o;
  logic [31:0] s_data_o;
  logic        s_we_o;
  logic        s_stb_o;
  logic        s_cyc_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_data_i;
  logic        s_ack_i;

  // master: the arbiter itself, which masters the shared slave bus
  modport master (
    input  m0_addr_i, m0_data_i, m0_we_i, m0_stb_i, m0_cyc_i, m0_sel_i,
    output m0_data_o, m0_ack_o,
    input  m1_addr_i, m1_data_i, m1_we_i, m1_stb_i, m1_cyc_i, m1_sel_i,
    output m1_data_o, m1_ack_o,
    output s_addr_o, s_data_o, s_we_o, s_stb_o, s_cyc_o, s_sel_o,
    input  s_data_i, s_ack_i
  );

  // slave: the surrounding masters and the slave, mirror view
  modport slave (
    output m0_addr_i, m0_data_i, m0_we_i, m0_stb_i, m0_cyc_i, m0_sel_i,
    input  m0_data_o, m0_ack_o,
    output m1_addr_i, m1_data_i, m1_we_i, m1_stb_i, m1_cyc_i, m1_sel_i,
    input  m1_data_o, m1_ack_o,
    input  s_addr_o, s_data_o, s_we_o, s_stb_o, s_cyc_o, s_sel_o,
    output s_data_i, s_ack_i
  );

endinterface

// File: rtl/wb_master_arbiter_timer.sv
// Bus watchdog for wb_master_arbiter; only instantiated when
// WB_ARB_WATCHDOG_EN is defined.
module wb_arb_timer
  import wb_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic expire
);

  localparam logic [WD_CNT_W-1:0] LIMIT = WD_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WD_CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !ack) begin
      count <= count + WD_CNT_W'(1);
    end
  end

  // A real ack in the limit cycle wins over the timeout.
  assign expire = enable && !ack && (count == LIMIT);

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with alternating priority.
// Optional bus watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_master_arbiter
  import wb_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  wb_master_arbiter_if.master bus,
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_master_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  arb_state_e state;
  arb_state_e state_nxt;
  logic       last_m0;
  logic       req0;
  logic       req1;
  logic       owner_cyc;
  logic       wd_expire;
  logic       to_ack;
  logic       done;

  assign req0 = bus.m0_cyc_i && bus.m0_stb_i;
  assign req1 = bus.m1_cyc_i && bus.m1_stb_i;

`ifdef WB_ARB_WATCHDOG_EN
  logic timeout_r;

  wb_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .ack    (bus.s_ack_i),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_r <= 1'b0;
    end else if (to_ack) begin
      timeout_r <= 1'b1;
    end
  end

  assign timeout_o = timeout_r;
`else
  assign wd_expire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // An owner that has already dropped cyc is aborted, not timed out.
  assign to_ack = wd_expire && owner_cyc;
  assign done   = (state != IDLE) && (bus.s_ack_i || to_ack);

  always_comb begin
    bus.s_addr_o = ZeroWord;
    bus.s_data_o = ZeroWord;
    bus.s_sel_o  = '0;
    bus.s_we_o   = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_cyc_o  = 1'b0;
    owner_cyc    = 1'b0;
    case (state)
      GNT_M0: begin
        bus.s_addr_o = bus.m0_addr_i;
        bus.s_data_o = bus.m0_data_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_stb_o  = bus.m0_stb_i;
        bus.s_cyc_o  = bus.m0_cyc_i;
        owner_cyc    = bus.m0_cyc_i;
      end
      GNT_M1: begin
        bus.s_addr_o = bus.m1_addr_i;
        bus.s_data_o = bus.m1_data_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_stb_o  = bus.m1_stb_i;
        bus.s_cyc_o  = bus.m1_cyc_i;
        owner_cyc    = bus.m1_cyc_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.m0_ack_o  = 1'b0;
    bus.m1_ack_o  = 1'b0;
    bus.m0_data_o = bus.s_data_i;
    bus.m1_data_o = bus.s_data_i;
    if (state == GNT_M0) begin
      bus.m0_ack_o = bus.s_ack_i || to_ack;
      if (to_ack) bus.m0_data_o = ZeroWord;
    end
    if (state == GNT_M1) begin
      bus.m1_ack_o = bus.s_ack_i || to_ack;
      if (to_ack) bus.m1_data_o = ZeroWord;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last_m0 ? GNT_M1 : GNT_M0;
        end else if (req0) begin
          state_nxt = GNT_M0;
        end else if (req1) begin
          state_nxt = GNT_M1;
        end
      end
      GNT_M0, GNT_M1: begin
        if (done || !owner_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_m0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (done) last_m0 <= (state == GNT_M0);
    end
  end

  assign grant_o = grant_of(state);

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Randomized self-checking bench for wb_master_arbiter against a
// transaction-level reference model of the arbitration rules.
module tb_wb_master_arbiter;

`ifdef WB_ARB_WATCHDOG_EN
  localparam bit          WD = 1'b1;
  localparam int unsigned TO = 4;
`else
  localparam bit          WD = 1'b0;
  localparam int unsigned TO = 255;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       tmo;

  always #5 clk = ~clk;

  wb_master_arbiter_if bus ();

  wb_master_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  // Reference model: who owns the bus (0 none, 1 m0, 2 m1), who finished last,
  // how long the owner has waited, and whether a timeout ever happened.
  int          owner;
  bit          last_was_m0;
  int unsigned waited;
  bit          saw_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit owner_cyc();
    if (owner == 1) return bus.m0_cyc_i;
    if (owner == 2) return bus.m1_cyc_i;
    return 1'b0;
  endfunction

  function automatic bit timeout_now();
    return WD && owner != 0 && !bus.s_ack_i && owner_cyc() && (waited == TO - 1);
  endfunction

  task automatic model_reset();
    owner       = 0;
    last_was_m0 = 1'b0;
    waited      = 0;
    saw_timeout = 1'b0;
  endtask

  task automatic check_outputs();
    bit          tack;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_sel;
    logic        e_we, e_stb, e_cyc;
    tack = timeout_now();
    e_addr = '0; e_data = '0; e_sel = '0; e_we = 0; e_stb = 0; e_cyc = 0;
    if (owner == 1) begin
      e_addr = bus.m0_addr_i; e_data = bus.m0_data_i; e_sel = bus.m0_sel_i;
      e_we = bus.m0_we_i; e_stb = bus.m0_stb_i; e_cyc = bus.m0_cyc_i;
    end else if (owner == 2) begin
      e_addr = bus.m1_addr_i; e_data = bus.m1_data_i; e_sel = bus.m1_sel_i;
      e_we = bus.m1_we_i; e_stb = bus.m1_stb_i; e_cyc = bus.m1_cyc_i;
    end
    check("grant",   32'(grant),         32'(owner));
    check("timeout", 32'(tmo),           32'(saw_timeout));
    check("s_cyc",   32'(bus.s_cyc_o),   32'(e_cyc));
    check("s_stb",   32'(bus.s_stb_o),   32'(e_stb));
    check("s_we",    32'(bus.s_we_o),    32'(e_we));
    check("s_sel",   32'(bus.s_sel_o),   32'(e_sel));
    check("s_addr",  bus.s_addr_o,       e_addr);
    check("s_data",  bus.s_data_o,       e_data);
    check("m0_ack",  32'(bus.m0_ack_o),  32'(owner == 1 && (bus.s_ack_i || tack)));
    check("m1_ack",  32'(bus.m1_ack_o),  32'(owner == 2 && (bus.s_ack_i || tack)));
    check("m0_data", bus.m0_data_o,      (owner == 1 && tack) ? 32'h0 : bus.s_data_i);
    check("m1_data", bus.m1_data_o,      (owner == 2 && tack) ? 32'h0 : bus.s_data_i);
  endtask

  task automatic model_advance();
    bit r0, r1, tack;
    r0   = bus.m0_cyc_i && bus.m0_stb_i;
    r1   = bus.m1_cyc_i && bus.m1_stb_i;
    tack = timeout_now();
    if (owner == 0) begin
      waited = 0;
      if (r0 && r1)  owner = last_was_m0 ? 2 : 1;
      else if (r0)   owner = 1;
      else if (r1)   owner = 2;
    end else if (bus.s_ack_i || tack) begin
      last_was_m0 = (owner == 1);
      if (tack) saw_timeout = 1'b1;
      owner = 0;
    end else if (!owner_cyc()) begin
      owner = 0;
    end else begin
      waited++;
    end
  endtask

  // One clock: check at negedge, advance model, return just after the posedge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    if (m == 0) begin
      bus.m0_cyc_i = cyc; bus.m0_stb_i = stb; bus.m0_we_i = we;
      bus.m0_addr_i = addr; bus.m0_data_i = data; bus.m0_sel_i = sel;
    end else begin
      bus.m1_cyc_i = cyc; bus.m1_stb_i = stb; bus.m1_we_i = we;
      bus.m1_addr_i = addr; bus.m1_data_i = data; bus.m1_sel_i = sel;
    end
  endtask

  task automatic idle_all();
    set_m(0, 0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0, '0);
    bus.s_ack_i  = 1'b0;
    bus.s_data_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    for (int m = 0; m < 2; m++) begin
      bit cyc;
      cyc = (m == 0) ? bus.m0_cyc_i : bus.m1_cyc_i;
      if (cyc) cyc = ($urandom_range(0, 9) != 0);
      else     cyc = ($urandom_range(0, 9) < 4);
      set_m(m, cyc, cyc && ($urandom_range(0, 9) != 0), 1'($urandom), $urandom, $urandom, 4'($urandom));
    end
    bus.s_ack_i  = ($urandom_range(0, 9) < 3);
    bus.s_data_i = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int grants[$];
    int exp_seq[5];
    exp_seq = '{1, 0, 2, 0, 1};

    idle_all();
    rst = 1'b1;
    model_reset();
    #2;
    do_reset();

    // Single m0 read, slave acks in the third granted cycle.
    set_m(0, 1, 1, 0, 32'h0000_1000, 32'h0, 4'hF);
    cycle();
    cycle();
    cycle();
    bus.s_ack_i = 1'b1; bus.s_data_i = 32'hCAFE_F00D;
    #1;
    check("r030_ack",   32'(bus.m0_ack_o), 32'd1);
    check("r030_data",  bus.m0_data_o,     32'hCAFE_F00D);
    check("r030_m1ack", 32'(bus.m1_ack_o), 32'd0);
    check("r030_grant", 32'(grant),        32'd1);
    cycle();
    idle_all();
    #1;
    check("r030_idle",  32'(grant),        32'd0);
    cycle();

    // Continuous contention with an always-acking slave alternates owners.
    do_reset();
    set_m(0, 1, 1, 1, 32'h10, 32'hA0, 4'h3);
    set_m(1, 1, 1, 0, 32'h20, 32'hB0, 4'hC);
    bus.s_ack_i = 1'b1; bus.s_data_i = 32'h5555_AAAA;
    cycle();
    for (int i = 0; i < 5; i++) begin
      grants.push_back(int'(grant));
      cycle();
    end
    for (int i = 0; i < 5; i++) check($sformatf("r031_seq%0d", i), 32'(grants[i]), 32'(exp_seq[i]));

    // m1 granted, then aborts with m0 pending.
    idle_all();
    set_m(1, 1, 1, 0, 32'h300, 32'h0, 4'hF);
    cycle();
    set_m(0, 1, 1, 0, 32'h400, 32'h0, 4'hF);
    cycle();
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
    #1;
    check("r032_cyc_fall", 32'(bus.s_cyc_o),  32'd0);
    check("r032_no_ack",   32'(bus.m1_ack_o), 32'd0);
    cycle();
    check("r032_idle", 32'(grant), 32'd0);
    cycle();
    check("r032_m0_next", 32'(grant), 32'd1);
    bus.s_ack_i = 1'b1;
    cycle();
    idle_all();
    cycle();

`ifdef WB_ARB_WATCHDOG_EN
    // Slave never acks: timeout ack in the 4th granted cycle, flag sticks.
    set_m(0, 1, 1, 0, 32'h500, 32'h0, 4'hF);
    bus.s_data_i = 32'h1234_5678;
    for (int i = 0; i < 4; i++) cycle();
    check("r033_to_ack",  32'(bus.m0_ack_o), 32'd1);
    check("r033_to_data", bus.m0_data_o,     32'h0);
    cycle();
    check("r033_sticky",  32'(tmo),          32'd1);
    // Ack arriving exactly in the limit cycle is a normal ack.
    set_m(1, 1, 1, 0, 32'h600, 32'h0, 4'hF);
    set_m(0, 0, 0, 0, '0, '0, '0);
    for (int i = 0; i < 4; i++) cycle();
    bus.s_ack_i = 1'b1; bus.s_data_i = 32'hDEAD_BEEF;
    #1;
    check("r022_data", bus.m1_data_o, 32'hDEAD_BEEF);
    cycle();
    idle_all();
    cycle();
    check("r033_still", 32'(tmo), 32'd1);
`else
    // Without the watchdog a stalled slave holds the grant indefinitely.
    set_m(0, 1, 1, 1, 32'h700, 32'h77, 4'hF);
    for (int i = 0; i < 1000; i++) cycle();
    check("r035_held", 32'(grant), 32'd1);
    check("r035_tmo",  32'(tmo),   32'd0);
    idle_all();
    cycle();
    cycle();
`endif

    // Asynchronous reset in the middle of an m1 transaction.
    set_m(1, 1, 1, 0, 32'h800, 32'h0, 4'hF);
    cycle();
    cycle();
    bus.s_ack_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("r034_cyc",   32'(bus.s_cyc_o),  32'd0);
    check("r034_ack",   32'(bus.m1_ack_o), 32'd0);
    check("r034_grant", 32'(grant),        32'd0);
    model_reset();
    bus.s_ack_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    check("r034_m1_first", 32'(grant), 32'd2);
    idle_all();
    cycle();

    // Random traffic against the reference model.
    for (int i = 0; i < 2500; i++) begin
      randomize_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, bus-watchdog limit in clk cycles (range 2..65535).
REQ-002 SHALL have ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have: m0_addr_i/m0_data_i  in  32 each; m0_we_i, m0_stb_i, m0_cyc_i  in  1 each; m0_sel_i  in  4. Master 0 is the data-side master.
REQ-005 SHALL have: m0_data_o  out  32; m0_ack_o  out  1.
REQ-006 SHALL have: m1_* ports with the same names, widths and directions as m0_*; master 1 is the instruction-side master.
REQ-007 SHALL have: s_addr_o, s_data_o  out  32; s_we_o, s_stb_o, s_cyc_o  out  1; s_sel_o  out  4; s_data_i  in  32; s_ack_i  in  1 (single shared Wishbone slave side).
REQ-008 SHALL have: grant_o  out  2  (01 = m0, 10 = m1, 00 = none); timeout_o  out  1  sticky watchdog flag.

Function
REQ-009 SHALL implement FSM states IDLE, GNT_M0, GNT_M1, held in registers.
REQ-010 A master requests when its cyc_i and stb_i are both 1.
REQ-011 IDLE: m0 request only -> GNT_M0; m1 request only -> GNT_M1; both -> GNT_M1 if last_m0 = 1, else GNT_M0; none -> stay.
REQ-012 last_m0 SHALL be a register set when a GNT_M0 transaction ends, cleared when a GNT_M1 transaction ends; this gives alternating grants under contention.
REQ-013 Latency: a request seen in IDLE at edge N SHALL appear on s_* outputs from cycle N+1; there is no combinational path from request to grant.
REQ-014 In GNT_Mx, s_addr/data/we/sel SHALL mirror master x combinationally; s_cyc_o = mx_cyc_i, s_stb_o = mx_stb_i.
REQ-015 In IDLE, s_cyc_o, s_stb_o, s_we_o SHALL be 0, and s_addr_o, s_data_o, s_sel_o SHALL be 0.
REQ-016 mx_ack_o SHALL equal s_ack_i only while in GNT_Mx; the non-granted master's ack SHALL be 0.
REQ-017 m0_data_o and m1_data_o SHALL both carry s_data_i, except on a timeout ack, when the granted master receives 32'h0.
REQ-018 A transaction ends on s_ack_i = 1 in GNT_Mx. The FSM SHALL then go to IDLE on the next edge, so a back-to-back request re-arbitrates after one IDLE cycle.
REQ-019 Abort: if the granted master drops cyc_i before ack, the FSM SHALL go to IDLE on the next edge with no ack, and last_m0 SHALL stay unchanged.
REQ-020 The watchdog counter SHALL clear on entry to a GNT state and increment each GNT cycle without s_ack_i.
REQ-021 When the count reaches TIMEOUT_CYCLES-1 without ack, the arbiter SHALL assert mx_ack_o for one cycle, force the master data to 0, set timeout_o, and go to IDLE, updating last_m0 as for a normal end.
REQ-022 If s_ack_i arrives in the same cycle the count reaches TIMEOUT_CYCLES-1, it SHALL be a normal ack with slave data and timeout_o unchanged.
REQ-023 grant_o SHALL reflect the registered state only.

Reset
REQ-024 On rst = 1, asynchronously: state IDLE, last_m0 0, counter 0, timeout_o 0. All s_cyc/stb/we, acks and grant_o SHALL be 0 while reset is held, including mid-transaction.
REQ-025 Only rst SHALL clear timeout_o.

Configuration
REQ-026 With macro WB_ARB_WATCHDOG_EN defined: REQ-020..REQ-022 apply.
REQ-027 Without it: the counter is removed, timeout_o is tied to 0, and a grant is held until ack or abort.

Structure
REQ-028 A shared package wb_defs SHALL hold the FSM state encoding, grant encodings, and the 32'h0 ZeroWord constant.
REQ-029 The watchdog SHALL be the sub-module wb_arb_timer (inputs clear/enable/ack, output expire); it is instantiated only under WB_ARB_WATCHDOG_EN.

Verification
REQ-030 m0 reads addr 0x1000; slave acks in the third granted cycle with 0xCAFEF00D -> m0_ack_o for 1 cycle, m0_data_o = 0xCAFEF00D, m1_ack_o = 0, grant_o = 01 then 00.
REQ-031 m0 and m1 request continuously, slave acks every cycle -> grant sequence M0, IDLE, M1, IDLE, M0; neither master is starved.
REQ-032 m1 granted, then m1 drops cyc before ack -> s_cyc_o falls the same cycle, IDLE next edge, no ack, pending m0 granted next.
REQ-033 TIMEOUT_CYCLES = 4, slave never acks m0 -> m0_ack_o at the 4th granted cycle, m0_data_o = 0, timeout_o = 1 and stays 1; a later normal transaction completes correctly.
REQ-034 rst pulsed mid GNT_M1 -> s_cyc_o, m1_ack_o and grant_o go to 0 without a clock edge; after release an m1 request is granted first (last_m0 = 0 gives m0 priority only under contention).
REQ-035 Build without WB_ARB_WATCHDOG_EN, slave stalls 1000 cycles -> grant held, no ack, timeout_o = 0.
